// File: rtl/ball_bounce_director.sv
// ball_bounce_director: drives the ball position register with periodic
// diagonal steps, reflecting the heading off the playfield edges on each tick.
module ball_bounce_director #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BALL_SIZE = 8,
    parameter int TICK_DIV  = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       serve,
    input  logic [9:0] ballX,
    input  logic [8:0] ballY,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic [1:0] heading,
    output logic       moving,
    output logic       bounce,
    output logic [7:0] bounce_count
);

    localparam int             CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [9:0]     X_MAX     = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0]     Y_MAX     = 10'(SCREEN_H - BALL_SIZE);

    typedef enum logic [2:0] {IDLE, UL, UR, DL, DR} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    step_reg, step_next;     // {up, down, left, right}
    logic          bounce_reg, bounce_next;
    logic [7:0]    count_reg, count_next;
    logic [1:0]    heading_reg, heading_next;
    logic          moving_reg;

    logic cur_v, cur_h, flip_v, flip_h, new_v, new_h;

    // Map a {vertical, horizontal} heading back onto its diagonal state.
    function automatic state_t diag_state(input logic v, input logic h);
        case ({v, h})
            2'b00:   return UL;
            2'b01:   return UR;
            2'b10:   return DL;
            default: return DR;
        endcase
    endfunction

    // Next-state: tick counting, edge reflection and step/bounce generation.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        step_next    = 4'b0000;
        bounce_next  = 1'b0;
        count_next   = count_reg;
        heading_next = 2'b01;

        cur_v  = (state_reg == DL) || (state_reg == DR);
        cur_h  = (state_reg == UR) || (state_reg == DR);
        // Only the wall being approached can reflect; a ball already at a
        // bound but heading away keeps its direction.
        flip_h = cur_h ? (ballX >= X_MAX) : (ballX == 10'd0);
        flip_v = cur_v ? ({1'b0, ballY} >= Y_MAX) : (ballY == 9'd0);
        new_h  = cur_h ^ flip_h;
        new_v  = cur_v ^ flip_v;

        if (state_reg == IDLE) begin
            cnt_next = '0;
            if (serve && enable) begin
                state_next = UR;
            end
        end else if (enable) begin
            if (cnt_reg == TICK_LAST) begin
                cnt_next    = '0;
                state_next  = diag_state(new_v, new_h);
                step_next   = {~new_v, new_v, ~new_h, new_h};
                bounce_next = flip_h | flip_v;
                // One count per reflecting tick, even when both axes flip.
                if ((flip_h || flip_v) && (count_reg != 8'hFF)) begin
                    count_next = count_reg + 8'd1;
                end
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end

        case (state_next)
            UL:      heading_next = 2'b00;
            UR:      heading_next = 2'b01;
            DL:      heading_next = 2'b10;
            DR:      heading_next = 2'b11;
            default: heading_next = 2'b01;
        endcase
    end

    // State and output registers; reset clears any in-flight pulse at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            step_reg    <= 4'b0000;
            bounce_reg  <= 1'b0;
            count_reg   <= 8'd0;
            heading_reg <= 2'b01;
            moving_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            step_reg    <= step_next;
            bounce_reg  <= bounce_next;
            count_reg   <= count_next;
            heading_reg <= heading_next;
            moving_reg  <= (state_next != IDLE);
        end
    end

    assign {up, down, left, right} = step_reg;
    assign bounce       = bounce_reg;
    assign bounce_count = count_reg;
    assign heading      = heading_reg;
    assign moving       = moving_reg;

endmodule

// File: tb/tb_ball_bounce_director.sv
// tb_ball_bounce_director: directed stimulus with a cycle-stamped scoreboard,
// followed by a closed-loop run against a model of the position register.
module tb_ball_bounce_director;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b1;
    logic       serve = 1'b0;
    logic [9:0] stim_x = 10'd320;
    logic [8:0] stim_y = 9'd240;
    logic [9:0] pos_x = 10'd320;
    logic [8:0] pos_y = 9'd240;
    logic       loop_mode = 1'b0;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       up, down, left, right, moving, bounce;
    logic [1:0] heading;
    logic [7:0] bounce_count;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int loop_steps = 0;
    logic loop_timeout = 1'b0;

    typedef struct {
        int         cyc;
        int         tag;
        logic [3:0] udlr;
        logic [1:0] hd;
        logic       b;
        logic [7:0] cnt;
        logic       mv;
    } sb_item_t;

    sb_item_t sbq[$];

    assign ball_x = loop_mode ? pos_x : stim_x;
    assign ball_y = loop_mode ? pos_y : stim_y;

    ball_bounce_director #(
        .SCREEN_W(640), .SCREEN_H(480), .BALL_SIZE(8), .TICK_DIV(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .serve(serve),
        .ballX(ball_x), .ballY(ball_y),
        .up(up), .down(down), .left(left), .right(right),
        .heading(heading), .moving(moving), .bounce(bounce),
        .bounce_count(bounce_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Position register: one pixel per cycle with a diagonal pair asserted.
    always @(posedge clk) begin
        if (!loop_mode) begin
            pos_x <= 10'd320;
            pos_y <= 9'd240;
        end else if ((up || down) && (left || right)) begin
            if (up)    pos_y <= pos_y - 9'd1;
            if (down)  pos_y <= pos_y + 9'd1;
            if (left)  pos_x <= pos_x - 10'd1;
            if (right) pos_x <= pos_x + 10'd1;
        end
    end

    task automatic push(input int c, input int tag, input logic [3:0] u,
                        input logic [1:0] hd, input logic b,
                        input logic [7:0] cn, input logic mv);
        sb_item_t it;
        it.cyc = c; it.tag = tag; it.udlr = u; it.hd = hd;
        it.b = b; it.cnt = cn; it.mv = mv;
        sbq.push_back(it);
    endtask

    task automatic go(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard away from the edge.
    initial begin : monitor
        sb_item_t   it;
        logic [3:0] act;
        logic       have_prev, prev_r, prev_d, rev_h, rev_v, ok;
        logic       timeout_seen;
        have_prev = 1'b0; prev_r = 1'b0; prev_d = 1'b0; timeout_seen = 1'b0;
        forever begin
            @(negedge clk);
            act = {up, down, left, right};
            if (loop_timeout && !timeout_seen) begin
                timeout_seen = 1'b1;
                total++; bad++;
                $display("FAIL loop_budget: steps=%0d required=2000", loop_steps);
            end
            if (loop_mode) begin
                if (act != 4'b0000 || bounce) begin
                    rev_h = have_prev && (right != prev_r);
                    rev_v = have_prev && (down != prev_d);
                    ok = (up ^ down) && (left ^ right)
                         && (bounce == (rev_h || rev_v))
                         && (!rev_h || ball_x == (right ? 10'd0 : 10'd632))
                         && (!rev_v || ball_y == (down ? 9'd0 : 9'd472))
                         && (ball_x <= 10'd632) && (ball_y <= 9'd472);
                    total++;
                    loop_steps++;
                    if (!ok) begin
                        bad++;
                        $display("FAIL loop_step %0d: got udlr=%b b=%b x=%0d y=%0d required diagonal pair, x<=632, y<=472, reversal only at a bound",
                                 loop_steps, act, bounce, ball_x, ball_y);
                    end else begin
                        $display("loop step %0d udlr=%b b=%b x=%0d y=%0d ok",
                                 loop_steps, act, bounce, ball_x, ball_y);
                    end
                    have_prev = 1'b1; prev_r = right; prev_d = down;
                end
            end else begin
                have_prev = 1'b0;
                while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                    it = sbq.pop_front();
                    total++; bad++;
                    $display("FAIL sb_missed tag=%0d: cycle %0d not observed, required check at that cycle", it.tag, it.cyc);
                end
                if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                    it = sbq.pop_front();
                    total++;
                    if ({act, heading, bounce, bounce_count, moving} !==
                        {it.udlr, it.hd, it.b, it.cnt, it.mv}) begin
                        bad++;
                        $display("FAIL sb tag=%0d cyc=%0d got udlr=%b hd=%b b=%b cnt=%0d mv=%b required udlr=%b hd=%b b=%b cnt=%0d mv=%b",
                                 it.tag, cyc, act, heading, bounce, bounce_count, moving,
                                 it.udlr, it.hd, it.b, it.cnt, it.mv);
                    end else begin
                        $display("cyc=%0d tag=%0d udlr=%b hd=%b b=%b cnt=%0d mv=%b ok",
                                 cyc, it.tag, act, heading, bounce, bounce_count, moving);
                    end
                end else if (act != 4'b0000 || bounce) begin
                    total++; bad++;
                    $display("FAIL sb_unexpected cyc=%0d: got udlr=%b b=%b required all 0", cyc, act, bounce);
                end
            end
        end
    end

    // Stimulus: directed vectors; each expected response queued with its cycle.
    initial begin : stimulus
        int s, p, t, budget;
        logic hh;
        logic [7:0] cn;
        rst = 1'b1;
        push(1, 1, 4'b0000, 2'b01, 1'b0, 8'd0, 1'b0);
        push(2, 1, 4'b0000, 2'b01, 1'b0, 8'd0, 1'b0);
        go(3); rst = 1'b0;

        // Serve from the centre: up+right every 4 cycles, first pulse at S+5.
        s = 5;
        go(s); serve = 1'b1;
        push(s,     2, 4'b0000, 2'b01, 1'b0, 8'd0, 1'b0);
        push(s + 1, 2, 4'b0000, 2'b01, 1'b0, 8'd0, 1'b1);
        push(s + 5,  3, 4'b1001, 2'b01, 1'b0, 8'd0, 1'b1);
        push(s + 9,  3, 4'b1001, 2'b01, 1'b0, 8'd0, 1'b1);
        push(s + 13, 3, 4'b1001, 2'b01, 1'b0, 8'd0, 1'b1);
        go(s + 1); serve = 1'b0;

        // Right wall from UR -> UL.
        go(s + 14); stim_x = 10'd632; stim_y = 9'd100;
        push(s + 17, 4, 4'b1010, 2'b00, 1'b1, 8'd1, 1'b1);
        // Left wall from UL -> UR.
        go(s + 18); stim_x = 10'd0; stim_y = 9'd100;
        push(s + 21, 5, 4'b1001, 2'b01, 1'b1, 8'd2, 1'b1);
        // Corner from UR -> DL, counted once.
        go(s + 22); stim_x = 10'd632; stim_y = 9'd0;
        push(s + 25, 6, 4'b0110, 2'b10, 1'b1, 8'd3, 1'b1);
        // Still at the corner but heading away: no flip.
        go(s + 26); stim_x = 10'd632; stim_y = 9'd0;
        push(s + 29, 7, 4'b0110, 2'b10, 1'b0, 8'd3, 1'b1);
        // Bottom wall from DL -> UL.
        go(s + 30); stim_x = 10'd100; stim_y = 9'd472;
        push(s + 33, 8, 4'b1010, 2'b00, 1'b1, 8'd4, 1'b1);
        // Left wall from UL -> UR.
        go(s + 34); stim_x = 10'd0; stim_y = 9'd200;
        push(s + 37, 9, 4'b1001, 2'b01, 1'b1, 8'd5, 1'b1);
        // Beyond the right bound from UR -> UL.
        go(s + 38); stim_x = 10'd700; stim_y = 9'd200;
        push(s + 41, 10, 4'b1010, 2'b00, 1'b1, 8'd6, 1'b1);

        // Pause 10 cycles with the counter at 1: step slips from S+45 to S+55.
        go(s + 42); stim_x = 10'd320; stim_y = 9'd240; enable = 1'b0;
        go(s + 52); enable = 1'b1;
        push(s + 55, 11, 4'b1010, 2'b00, 1'b0, 8'd6, 1'b1);
        // Enable low exactly on the tick cycle: tick deferred one cycle.
        go(s + 58); enable = 1'b0;
        go(s + 59); enable = 1'b1;
        push(s + 60, 12, 4'b1010, 2'b00, 1'b0, 8'd6, 1'b1);

        // 300 alternating wall ticks; count saturates at 255.
        hh = 1'b0;
        for (int k = 0; k < 300; k++) begin
            t = s + 63 + 4 * k;
            go(t - 2);
            stim_x = hh ? 10'd632 : 10'd0;
            hh = ~hh;
            cn = (7 + k > 255) ? 8'd255 : 8'(7 + k);
            if (k < 299) push(t + 1, 13, {1'b1, 1'b0, ~hh, hh}, {1'b0, hh}, 1'b1, cn, 1'b1);
        end

        // Reset lands on the 300th step pulse: cleared within the same cycle.
        p = s + 1260;
        go(p); rst = 1'b1;
        push(p,     14, 4'b0000, 2'b01, 1'b0, 8'd0, 1'b0);
        push(p + 1, 14, 4'b0000, 2'b01, 1'b0, 8'd0, 1'b0);
        go(p + 2); rst = 1'b0;
        push(p + 10, 15, 4'b0000, 2'b01, 1'b0, 8'd0, 1'b0);
        // Serve while paused must not launch.
        go(p + 12); enable = 1'b0; serve = 1'b1;
        go(p + 13); enable = 1'b1; serve = 1'b0;
        push(p + 14, 16, 4'b0000, 2'b01, 1'b0, 8'd0, 1'b0);

        // Closed loop from (320,240) for 2000 steps.
        go(p + 18); loop_mode = 1'b1;
        go(p + 20); serve = 1'b1;
        go(p + 21); serve = 1'b0;
        budget = 0;
        while (loop_steps < 2000 && budget < 8200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (loop_steps < 2000) loop_timeout = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_bounce_director.md
# ball_bounce_director

Autonomous motion source for the ball position register. Each movement tick, it reads the current ball position, reflects its diagonal heading off the screen edges, and emits a one-cycle diagonal step command on up/down/left/right. The position register moves by one pixel per cycle in which a diagonal pair is asserted and holds otherwise. The director therefore sits between the position register's outputs and its direction inputs, closing the loop.

## Interface
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- BALL_SIZE, 8, ball edge length; right/bottom bounds are SCREEN_W-BALL_SIZE / SCREEN_H-BALL_SIZE
- TICK_DIV, 250000, clocks per movement step; legal minimum 4
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  high = motion runs; low = pause (counter frozen, no steps, heading held)
- serve  in  1  one-cycle request to launch the ball from IDLE
- ballX  in  10  current ball left edge
- ballY  in  9  current ball top edge
- up, down, left, right  out  1 each  step command; pulses only as a diagonal pair, one cycle wide
- heading  out  2  {vertical, horizontal}: bit1 1=down 0=up, bit0 1=right 0=left
- moving  out  1  high when not in IDLE
- bounce  out  1  one-cycle pulse coincident with a step whose heading was flipped
- bounce_count  out  8  wall reflections since reset, saturating at 255

## Operation
- States: IDLE, UL, UR, DL, DR. heading mirrors the diagonal state; in IDLE heading = 2'b01 (UR, the serve direction).
- IDLE: tick counter held at 0. A serve with enable high moves the FSM to UR on the next edge. serve outside IDLE is ignored.
- Diagonal states: the tick counter counts 0..TICK_DIV-1 while enable is high and wraps. The tick fires on the cycle the counter equals TICK_DIV-1.
- On a tick, evaluate the sampled ballX/ballY against the current heading:
  - left and ballX==0 → horizontal becomes right
  - right and ballX>=SCREEN_W-BALL_SIZE → horizontal becomes left
  - up and ballY==0 → vertical becomes down
  - down and ballY>=SCREEN_H-BALL_SIZE → vertical becomes up
  - Corner case: both axes flip on the same tick.
  - At a bound while already heading away: no flip.
  - Comparisons are unsigned, with ballY zero-extended to 10 bits.
- The step issued for this tick uses the updated heading. bounce pulses if either axis flipped. bounce_count increments by 1 per flipping tick, not per axis, and saturates.
- All outputs are registered; no combinational path from ballX/ballY to up/down/left/right.
- enable low: counter and state frozen, step outputs 0. Resuming continues the count from the frozen value.

## Timing
- Reset values (asynchronous):
  - state IDLE, counter 0
  - up/down/left/right 0, bounce 0, bounce_count 0
  - heading 2'b01, moving 0
- serve at cycle S (IDLE, enable=1): moving=1 from S+1; first tick at S+TICK_DIV; first step pulse at S+TICK_DIV+1.
- Tick at cycle T: step pair, bounce, heading, and the bounce_count update are all visible at T+1 for exactly one cycle (bounce_count persists). The position register updates at the end of T+1. TICK_DIV>=4 guarantees ballX/ballY are settled before the next evaluation.
- Step pulses are spaced exactly TICK_DIV cycles apart while enable is held high.
- Between steps, up/down/left/right are all 0, so the position register holds.
- rst mid-step truncates any pulse immediately and returns to IDLE. A new serve is required.
- enable dropping on a tick cycle: the tick is not taken, and no step or bounce occurs.

## Test plan
- Reset then serve, TICK_DIV=4, ballX=320, ballY=240: steps up+right every 4 cycles, heading=01, bounce never asserted, first pulse 5 cycles after serve.
- Right wall: heading UR, ballX=632, ballY=100 at tick → step up+left, heading=00, bounce=1 for one cycle, bounce_count=1.
- Corner: heading UR, ballX=632, ballY=0 at tick → step down+left, heading=10, single bounce, bounce_count +1 only.
- Pause: drop enable for 10 cycles mid-count → no pulses and counter frozen. Next step arrives after the remaining count, once enable is high again.
- Saturation and reset: force 300 wall ticks → bounce_count=255. Assert rst mid-pulse → all outputs at reset values within the same cycle, moving=0, and no steps until serve.
- Closed loop with the position register: from reset position (320,240), run 2000 steps → ballX stays within 0..632 and ballY within 0..472, with each reversal at a bound.
